// File: rtl/riscv_core_16booth_seq_mul.sv
// riscv_core_16booth_seq_mul: iterative radix-16 Booth multiplier, one 5-bit group per cycle.
// Ports: i_clk/i_rst (async active-high reset); request i_mul_valid/o_mul_ready with operands
// i_mul_a, i_mul_b and signedness flags i_mul_a_signed, i_mul_b_signed; result o_res_valid/i_res_ready
// with o_res_product (2*XLEN bits); o_busy high while an operation is in flight or awaiting pickup.
// Optional macro RISCV_CORE_BOOTH_EARLY_TERM_EN: finish as soon as all remaining digits are zero.
module riscv_core_16booth_seq_mul #(
    parameter int XLEN = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_mul_valid,
    output logic              o_mul_ready,
    input  logic [XLEN-1:0]   i_mul_a,
    input  logic [XLEN-1:0]   i_mul_b,
    input  logic              i_mul_a_signed,
    input  logic              i_mul_b_signed,
    output logic              o_res_valid,
    input  logic              i_res_ready,
    output logic [2*XLEN-1:0] o_res_product,
    output logic              o_busy
);
    localparam int N  = (XLEN + 4) / 4;
    localparam int CW = $clog2(N);
    localparam int AW = 2 * XLEN + 8;
    localparam int MW = XLEN + 5;
    localparam int BW = XLEN + 5;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state, state_nxt;
    logic [XLEN:0]   a_q;
    logic [BW-1:0]   b_sh;
    logic [CW-1:0]   cnt;
    logic [AW-1:0]   acc;
    logic [4:0]      grp, dig, dig_abs;
    logic            neg, last, accept, acc_unused;
    logic [MW-1:0]   a_w, mag, pp;
    logic [AW-1:0]   pp_sh;

    assign accept = i_mul_valid && state == IDLE;
    // b_sh holds {B_ext, b[-1]} shifted right 4 per cycle; the low 5 bits are the current group
    assign grp     = b_sh[4:0];
    // {g4,g3,g2,g1} read as signed 4-bit gives -8g4+4g3+2g2+g1; adding g0 completes the digit
    assign dig     = {grp[4], grp[4:1]} + {4'b0, grp[0]};
    assign neg     = dig[4];
    assign dig_abs = neg ? -dig : dig;
    assign a_w     = {{4{a_q[XLEN]}}, a_q};

    always_comb begin
        mag = '0;
        case (dig_abs)
            5'd1: mag = a_w;
            5'd2: mag = a_w << 1;
            5'd3: mag = a_w + (a_w << 1);
            5'd4: mag = a_w << 2;
            5'd5: mag = a_w + (a_w << 2);
            5'd6: mag = (a_w << 1) + (a_w << 2);
            5'd7: mag = (a_w << 3) - a_w;
            5'd8: mag = a_w << 3;
            default: mag = '0;
        endcase
    end

    assign pp    = neg ? -mag : mag;
    assign pp_sh = {{(AW - MW){pp[MW-1]}}, pp} << {cnt, 2'b00};

`ifdef RISCV_CORE_BOOTH_EARLY_TERM_EN
    // Bits above the current group (b_sh[4] doubles as the next boundary bit); uniform means
    // every later digit is zero. The right shift sign-fills, so stale top bits stay consistent.
    assign last = (~|b_sh[BW-1:4]) || (&b_sh[BW-1:4]) || cnt == CW'(N - 1);
`else
    assign last = cnt == CW'(N - 1);
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept ? BUSY : IDLE;
            BUSY:    state_nxt = last ? DONE : BUSY;
            DONE:    state_nxt = i_res_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else state <= state_nxt;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            a_q  <= '0;
            b_sh <= '0;
            cnt  <= '0;
            acc  <= '0;
        end else if (accept) begin
            a_q  <= {i_mul_a_signed & i_mul_a[XLEN-1], i_mul_a};
            b_sh <= {{4{i_mul_b_signed & i_mul_b[XLEN-1]}}, i_mul_b, 1'b0};
            cnt  <= '0;
            acc  <= '0;
        end else if (state == BUSY) begin
            acc  <= acc + pp_sh;
            b_sh <= {{4{b_sh[BW-1]}}, b_sh[BW-1:4]};
            cnt  <= cnt + 1'b1;
        end
    end

    // Guard bits of the accumulator only absorb carries; the product is taken modulo 2^(2*XLEN)
    assign acc_unused    = ^acc[AW-1:2*XLEN];
    assign o_res_product = acc[2*XLEN-1:0];
    assign o_mul_ready   = state == IDLE;
    assign o_res_valid   = state == DONE;
    assign o_busy        = state != IDLE;
endmodule

// File: tb/tb_riscv_core_16booth_seq_mul.sv
// tb_riscv_core_16booth_seq_mul: directed self-checking bench for the radix-16 Booth multiplier.
module tb_riscv_core_16booth_seq_mul;
    localparam int XLEN = 64;
`ifdef RISCV_CORE_BOOTH_EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              i_mul_valid = 1'b0;
    logic              o_mul_ready;
    logic [XLEN-1:0]   i_mul_a = '0;
    logic [XLEN-1:0]   i_mul_b = '0;
    logic              i_mul_a_signed = 1'b0;
    logic              i_mul_b_signed = 1'b0;
    logic              o_res_valid;
    logic              i_res_ready = 1'b0;
    logic [2*XLEN-1:0] o_res_product;
    logic              o_busy;

    int checks = 0;
    int errors = 0;

    riscv_core_16booth_seq_mul #(.XLEN(XLEN)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_mul_valid(i_mul_valid), .o_mul_ready(o_mul_ready),
        .i_mul_a(i_mul_a), .i_mul_b(i_mul_b), .i_mul_a_signed(i_mul_a_signed),
        .i_mul_b_signed(i_mul_b_signed), .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
        .o_res_product(o_res_product), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                             input logic as, input logic bs);
        logic [129:0] ea, eb, p;
        ea = {{66{as & a[63]}}, a};
        eb = {{66{bs & b[63]}}, b};
        p  = ea * eb;
        return p[127:0];
    endfunction

    // Returns just after the accepting edge, i.e. in cycle 1; operands are then scrambled.
    task automatic start(input logic [63:0] a, input logic [63:0] b, input logic as, input logic bs);
        @(negedge i_clk);
        i_mul_a = a; i_mul_b = b; i_mul_a_signed = as; i_mul_b_signed = bs; i_mul_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_mul_valid = 1'b0;
        i_mul_a = {$urandom, $urandom}; i_mul_b = {$urandom, $urandom};
        i_mul_a_signed = ~as; i_mul_b_signed = ~bs;
    endtask

    task automatic wait_check(input string tag, input logic [127:0] exp, input int exp_lat);
        int lat;
        lat = 1;
        while (!o_res_valid && lat < 200) begin
            @(posedge i_clk);
            #1;
            lat++;
        end
        check({tag, "_valid"}, 128'(o_res_valid), 128'(1));
        if (exp_lat > 0) check({tag, "_latency"}, 128'(lat), 128'(exp_lat));
        check({tag, "_product"}, o_res_product, exp);
    endtask

    task automatic release_res(input string tag);
        @(negedge i_clk);
        i_res_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_res_ready = 1'b0;
        check({tag, "_valid_drop"}, 128'(o_res_valid), 128'(0));
        check({tag, "_ready_back"}, 128'(o_mul_ready), 128'(1));
    endtask

    task automatic run(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic as, input logic bs, input logic [127:0] exp, input int exp_lat);
        start(a, b, as, bs);
        wait_check(tag, exp, exp_lat);
        release_res(tag);
    endtask

    initial begin
        logic [127:0] exp;
        logic [63:0]  ra, rb;
        logic         rsa, rsb;
        int           nv;
        #1;
        check("rst_ready", 128'(o_mul_ready), 128'(1));
        check("rst_valid", 128'(o_res_valid), 128'(0));
        check("rst_busy", 128'(o_busy), 128'(0));
        check("rst_product", o_res_product, 128'(0));
        @(negedge i_clk);
        i_rst = 1'b0;

        run("unsigned_max", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0,
            128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 18);
        run("signed_m3x7", -64'sd3, 64'd7, 1'b1, 1'b1,
            128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFEB, ET ? 2 : 18);
        run("mixed_minx2", 64'h8000_0000_0000_0000, 64'd2, 1'b1, 1'b0,
            128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000, ET ? 2 : 18);
        run("digit_pm8", 64'd1, 64'h8888_8888_8888_8888, 1'b0, 1'b0,
            128'h0000_0000_0000_0000_8888_8888_8888_8888, 18);
        run("small_5x3", 64'd5, 64'd3, 1'b0, 1'b0, 128'd15, ET ? 2 : 18);
        run("signed_9xm1", 64'd9, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1,
            128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF7, ET ? 2 : 18);
        run("mixed_2xm1", 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1,
            128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, ET ? 2 : 18);
        run("zero_a", 64'd0, 64'h1234, 1'b0, 1'b0, 128'd0, ET ? 5 : 18);

        // Back-pressure: result held 10 cycles while new requests are ignored
        exp = ref_mul(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0);
        start(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0);
        wait_check("bp", exp, 18);
        for (int i = 0; i < 10; i++) begin
            @(negedge i_clk);
            i_mul_valid = 1'b1; i_mul_a = {$urandom, $urandom}; i_mul_b = {$urandom, $urandom};
            @(posedge i_clk);
            #1;
            check("bp_hold_product", o_res_product, exp);
            check("bp_hold_ready", 128'(o_mul_ready), 128'(0));
            check("bp_hold_valid", 128'(o_res_valid), 128'(1));
        end
        @(negedge i_clk);
        i_mul_a = 64'd7; i_mul_b = 64'd6; i_mul_a_signed = 1'b0; i_mul_b_signed = 1'b0;
        i_mul_valid = 1'b1; i_res_ready = 1'b1;
        @(posedge i_clk);
        #1;
        check("bp_release_idle", 128'(o_mul_ready), 128'(1));
        check("bp_release_valid", 128'(o_res_valid), 128'(0));
        @(posedge i_clk);
        #1;
        i_mul_valid = 1'b0; i_res_ready = 1'b0;
        i_mul_a = {$urandom, $urandom}; i_mul_b = {$urandom, $urandom};
        check("bp_next_accepted", 128'(o_busy), 128'(1));
        wait_check("bp_next", 128'd42, ET ? 2 : 18);
        release_res("bp_next");

        // Reset in BUSY cycle 5 aborts the operation
        start(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        repeat (4) @(posedge i_clk);
        #2;
        i_rst = 1'b1;
        #1;
        check("midrst_busy", 128'(o_busy), 128'(0));
        check("midrst_ready", 128'(o_mul_ready), 128'(1));
        check("midrst_valid", 128'(o_res_valid), 128'(0));
        check("midrst_product", o_res_product, 128'(0));
        @(negedge i_clk);
        i_rst = 1'b0;
        nv = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge i_clk);
            #1;
            if (o_res_valid) nv++;
        end
        check("midrst_no_stale_valid", 128'(nv), 128'(0));
        run("after_rst_11x13", 64'd11, 64'd13, 1'b0, 1'b0, 128'd143, ET ? 3 : 18);

        for (int i = 0; i < 12; i++) begin
            ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
            rsa = 1'($urandom); rsb = 1'($urandom);
            if (i % 4 == 1) rb = {{48{rb[15]}}, rb[15:0]};
            run("random", ra, rb, rsa, rsb, ref_mul(ra, rb, rsa, rsb), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
